keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   4x4 matrix keypad scanner: the input-side counterpart of the 7-seg digit drivers.
//   Drives the keypad columns one at a time, active low, and samples the rows (pulled up).
//   Debounces a press and reports one 4-bit key code with a single-cycle valid strobe.
//   Sits beside the display blocks on the 27 MHz board clock and feeds the digit/animation logic.
// PARAMETERS
//   CLK_HZ        27_000_000  input clock frequency
//   SCAN_HZ       1_000       scan tick rate; one column step or debounce sample per tick
//   DEB_TICKS     8           consecutive stable samples needed for press and for release
//   RPT_DELAY     500         ticks held before the first auto-repeat (KEYPAD_REPEAT_EN only)
//   RPT_PERIOD    100         ticks between later repeats (KEYPAD_REPEAT_EN only)
// PORTS
//   clk        in   1  board clock
//   nrst       in   1  asynchronous reset, active low
//   row        in   4  keypad rows; asynchronous, active low, external pull-ups
//   col        out  4  keypad column drive; one-hot low
//   key_code   out  4  last accepted key = row_idx*4 + col_idx
//   key_valid  out  1  one-clk strobe; key_code is new on this cycle
//   key_held   out  1  high while the accepted key remains pressed
// BEHAVIOUR
//   Reset values (nrst low, asynchronous): col=4'b1110, key_code=0, key_valid=0, key_held=0,
//     state=SCAN, col_idx=0, tick counter=0, debounce counter=0.
//   Sync: row passes through a 2-FF synchroniser before any use (2 clk latency).
//   Tick: tick counter counts 0..CLK_HZ/SCAN_HZ-1 and wraps; tick is 1 clk wide at the wrap.
//   All FSM decisions happen only on tick cycles; outputs hold between ticks.
//   hit: any synchronised row bit low. sel_row: lowest-index low row (row0 has priority).
//   FSM:
//     SCAN: on tick, if hit -> latch {sel_row,col_idx}, deb=1, go DEB_PRESS, col frozen;
//           else col_idx++ (3 wraps to 0), col rotates 1110->1101->1011->0111->1110.
//     DEB_PRESS: on tick, if the latched row is still low then deb++; if deb reaches DEB_TICKS ->
//           key_code=latched, key_valid=1 on the next clk, key_held=1, go HELD.
//           If the latched row is high -> deb=0, go SCAN; col advances on the next tick.
//     HELD: col stays frozen. On tick, if the latched row is high -> deb=1, go DEB_RELEASE.
//     DEB_RELEASE: on tick, if the row is high then deb++; if deb reaches DEB_TICKS -> key_held=0,
//           go SCAN. If the row goes low again -> back to HELD; no new key_valid.
//   Press-to-valid latency: DEB_TICKS ticks after the first detecting tick, plus 1 clk.
//   A second key pressed while in HELD is ignored; only the latched key is tracked.
//   Two keys in the same column give the lower row. Ghosting is not resolved.
//   key_valid is never high for two consecutive clks.
//   A row glitch shorter than 1 tick is filtered when it lands between ticks.
//   nrst asserted mid-debounce or mid-hold: immediate return to reset values, no strobe.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined:
//     - In HELD, a repeat counter counts ticks.
//     - At RPT_DELAY, and every RPT_PERIOD after that, key_valid pulses 1 clk
//       with key_code unchanged.
//     - The counter clears on entry to HELD.
//     - The counter is not cleared by DEB_RELEASE bounce back to HELD; counting resumes.
//   KEYPAD_REPEAT_EN undefined: exactly one key_valid per accepted press; no repeat logic.
// STRUCTURE
//   keypad_pkg: typedef enum logic[1:0] {SCAN,DEB_PRESS,HELD,DEB_RELEASE} kp_state_t;
//     typedef logic[3:0] key_code_t; localparam COL_IDLE=4'b1110.
//   Sub-module keypad_tick holds the tick counter. It takes clk, nrst and the wrap value
//     and outputs tick.
//   The FSM, synchroniser and column driver stay in keypad_scan.
// TESTING (bench params: CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 clk, DEB_TICKS=3)
//   1. Reset, no keys -> col cycles 1110,1101,1011,0111 every 10 clk; key_valid stays 0.
//   2. Hold row[2] low while col=1011 -> 3 ticks later key_valid=1 for one clk,
//      key_code=4'd10, key_held=1.
//   3. Release that key -> key_held=0 after 3 high ticks; col resumes rotation from 1011.
//   4. Press row[1] for 1 tick only, then release -> no key_valid; FSM returns to SCAN.
//   5. row[0] and row[3] low together on col 1110 -> key_code=0.
//      Assert nrst during DEB_PRESS -> col=1110, no strobe.
//   6. KEYPAD_REPEAT_EN, RPT_DELAY=5, RPT_PERIOD=2, key held 12 ticks
//      -> key_valid at accept, then 5 ticks later, then every 2 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   kp_state_t  : scanner FSM states
//   key_code_t  : key code, {row_idx, col_idx}
//   COL_IDLE    : column drive after reset (column 0 low)
//   col_drive() : column index -> one-hot-low column drive
//   first_low() : index of the lowest-numbered low row (row 0 wins)
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} kp_state_t;
  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] c;
    case (idx)
      2'd0:    c = COL_IDLE;
      2'd1:    c = 4'b1101;
      2'd2:    c = 4'b1011;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    casez (r)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad scanner bus: physical matrix lines plus the decoded key report.
//   row       : keypad rows, active low (driven by the keypad)
//   col       : column drive, one-hot low (driven by the scanner)
//   key_code  : last accepted key, row_idx*4 + col_idx
//   key_valid : one-clk strobe, key_code is new this cycle
//   key_held  : high while the accepted key stays pressed
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [3:0] row;
  logic [3:0] col;
  key_code_t  key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output col, output key_code, output key_valid, output key_held);
  modport slave  (output row, input col, input key_code, input key_valid, input key_held);

endinterface

// File: rtl/keypad_tick.sv
// Free-running tick generator for the keypad scanner.
//   clk, nrst : clock, async active-low reset
//   wrap      : terminal count; counter runs 0..wrap and wraps
//   tick      : high for the one clk where the counter sits at wrap
module keypad_tick #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [CNT_W-1:0] wrap,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == wrap);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
//   clk, nrst : board clock, async active-low reset
//   kp        : keypad_scan_if.master (row in; col, key_code, key_valid, key_held out)
// Columns are driven low one at a time; rows are pulled up, so a pressed key
// pulls its row low while its column is driven. Once a key is seen the column
// is frozen and only the latched row is tracked until the key is released.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while held).
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int DEB_TICKS  = 8,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100
) (
  input  logic          clk,
  input  logic          nrst,
  keypad_scan_if.master kp
);

  localparam int DIV    = CLK_HZ / SCAN_HZ;
  localparam int TCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TCNT_W-1:0] TICK_WRAP = TCNT_W'(DIV - 1);

  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS);
  localparam logic [DEB_W-1:0] DEB_ONE = {{(DEB_W-1){1'b0}}, 1'b1};

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(RPT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(RPT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};
`endif

  // ---------------------------------------------------------------- tick
  logic tick;

  keypad_tick #(.CNT_W(TCNT_W)) u_tick (
    .clk  (clk),
    .nrst (nrst),
    .wrap (TICK_WRAP),
    .tick (tick)
  );

  // ------------------------------------------------------- row synchroniser
  // Rows idle high (pull-ups), so the sync stages reset to all ones.
  logic [3:0] row_s1_q, row_s2_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
    end
  end

  logic       hit;
  logic [1:0] sel_row;
  logic       lat_low;

  // ------------------------------------------------------------------ FSM
  kp_state_t       state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      lat_row_q, lat_row_d;
  logic [1:0]      lat_col_q, lat_col_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  key_code_t       key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_nxt;
  logic             rpt_arm_q, rpt_arm_d;  // first repeat done; use RPT_PERIOD from now on
`endif

  assign hit     = ~&row_s2_q;
  assign sel_row = first_low(row_s2_q);
  assign lat_low = ~row_s2_q[lat_row_q];

  // deb counts samples including the detecting one; a key is accepted on the
  // tick after the count has reached DEB_TICKS with the row still in the new
  // level, i.e. DEB_TICKS ticks after the detecting tick.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_arm_d   = rpt_arm_q;
    rpt_nxt     = rpt_q + RPT_ONE;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            lat_row_d = sel_row;
            lat_col_d = col_idx_q;
            deb_d     = DEB_ONE;
            state_d   = DEB_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (lat_low) begin
            if (deb_q == DEB_MAX) begin
              key_code_d  = {lat_row_q, lat_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_d       = '0;
              state_d     = HELD;
`ifdef KEYPAD_REPEAT_EN
              rpt_d       = '0;
              rpt_arm_d   = 1'b0;
`endif
            end else begin
              deb_d = deb_q + DEB_ONE;
            end
          end else begin
            // Bounce: resume scanning; the column moves on at the next tick.
            deb_d   = '0;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!lat_low) begin
            deb_d   = DEB_ONE;
            state_d = DEB_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            // Not cleared on a release bounce back into HELD, so counting resumes.
            if (rpt_nxt == (rpt_arm_q ? RPT_PER : RPT_DLY)) begin
              key_valid_d = 1'b1;
              rpt_d       = '0;
              rpt_arm_d   = 1'b1;
            end else begin
              rpt_d = rpt_nxt;
            end
          end
`endif
        end
        DEB_RELEASE: begin
          if (!lat_low) begin
            if (deb_q == DEB_MAX) begin
              key_held_d = 1'b0;
              deb_d      = '0;
              state_d    = SCAN;
            end else begin
              deb_d = deb_q + DEB_ONE;
            end
          end else begin
            deb_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      lat_row_q   <= 2'd0;
      lat_col_q   <= 2'd0;
      deb_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      rpt_arm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_arm_q   <= rpt_arm_d;
`endif
    end
  end

  // ------------------------------------------------------------- outputs
  assign kp.col       = col_drive(col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: CLK_HZ=1000, SCAN_HZ=100 (tick every 10 clk),
// DEB_TICKS=3. A small matrix model turns the set of pressed keys plus the
// column drive into the row lines. Time is counted in negedges since the last
// reset release (cyc); with the tick at every 10th posedge, FSM decisions land
// on posedges 10, 20, 30, ... and are observed at the matching negedge.
module tb_keypad_scan;
  import keypad_pkg::*;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c
  int          cyc, n_asrt, n_fail;
  int          vcount = 0;     // key_valid pulses seen
  int          dbl = 0;        // key_valid high on two consecutive clks
  logic        prev_v = 1'b0;

  keypad_scan_if kp ();

  keypad_scan #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEB_TICKS(3), .RPT_DELAY(5), .RPT_PERIOD(2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign kp.row[r] = ~|(pressed[r*4 +: 4] & ~kp.col);
  end

  always @(posedge clk) begin
    if (kp.key_valid) begin
      vcount++;
      if (prev_v) dbl++;
    end
    prev_v = kp.key_valid;
  end

  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic restart();
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    cyc    = 0;

    // 1. reset values, then idle column rotation
    @(negedge clk);
    chk("rst_col",   kp.col, 4'b1110);
    chk("rst_code",  kp.key_code, 4'd0);
    chk("rst_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("rst_held",  {3'b0, kp.key_held}, 4'd0);
    nrst = 1'b1;
    cyc  = 0;
    go_to(9);   chk("scan_c9",  kp.col, 4'b1110);
    go_to(10);  chk("scan_c10", kp.col, 4'b1101);
    go_to(20);  chk("scan_c20", kp.col, 4'b1011);
    go_to(30);  chk("scan_c30", kp.col, 4'b0111);
    go_to(40);  chk("scan_c40", kp.col, 4'b1110);
    chk_n("idle_no_valid", vcount, 0);

    // 2. key 10 (row 2, col 2): seen at tick 70, accepted at tick 100
    pressed[10] = 1'b1;
    go_to(80);  chk("press_col_frozen", kp.col, 4'b1011);
    go_to(99);  chk("press_valid_early", {3'b0, kp.key_valid}, 4'd0);
    go_to(100); chk("press_valid", {3'b0, kp.key_valid}, 4'd1);
                chk("press_code",  kp.key_code, 4'd10);
                chk("press_held",  {3'b0, kp.key_held}, 4'd1);
    go_to(101); chk("press_valid_1clk", {3'b0, kp.key_valid}, 4'd0);

    // 3. release: high seen at tick 120, key_held drops at tick 150
    go_to(110); pressed = '0;
    go_to(149); chk("rel_held_early", {3'b0, kp.key_held}, 4'd1);
    go_to(150); chk("rel_held", {3'b0, kp.key_held}, 4'd0);
                chk("rel_col", kp.col, 4'b1011);
    go_to(160); chk("rel_col_resume", kp.col, 4'b0111);
    chk_n("rel_one_valid", vcount, 1);

    // 4. key 5 (row 1, col 1) present for one tick only
    go_to(170); pressed[5] = 1'b1;
    go_to(190); pressed = '0;
    go_to(195); chk("bounce_col_frozen", kp.col, 4'b1101);
    go_to(200); chk("bounce_col_hold",   kp.col, 4'b1101);
    go_to(210); chk("bounce_col_adv",    kp.col, 4'b1011);
                chk("bounce_held", {3'b0, kp.key_held}, 4'd0);
    chk_n("bounce_no_valid", vcount, 1);

    // 5. keys 0 and 12 together in column 0 -> row 0 wins
    pressed[0]  = 1'b1;
    pressed[12] = 1'b1;
    go_to(269); chk("prio_valid_early", {3'b0, kp.key_valid}, 4'd0);
    go_to(270); chk("prio_valid", {3'b0, kp.key_valid}, 4'd1);
                chk("prio_code",  kp.key_code, 4'd0);
                chk("prio_held",  {3'b0, kp.key_held}, 4'd1);
    go_to(275);
    nrst = 1'b0;
    pressed = '0;
    #1;
    chk("hold_rst_col",  kp.col, 4'b1110);
    chk("hold_rst_held", {3'b0, kp.key_held}, 4'd0);
    restart();

    // sub-tick glitch on key 0 between ticks is filtered
    go_to(2);   pressed[0] = 1'b1;
    go_to(6);   pressed[0] = 1'b0;
    go_to(10);  chk("glitch_col", kp.col, 4'b1101);

    // reset in DEB_PRESS: key 10 seen at tick 30, reset at cycle 45
    pressed[10] = 1'b1;
    go_to(35);  chk("deb_col_frozen", kp.col, 4'b1011);
    go_to(45);
    nrst = 1'b0;
    #1;
    chk("deb_rst_col",   kp.col, 4'b1110);
    chk("deb_rst_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("deb_rst_held",  {3'b0, kp.key_held}, 4'd0);
    pressed = '0;
    restart();
    go_to(10);  chk("post_rst_col", kp.col, 4'b1101);
    go_to(60);
    chk_n("total_valid", vcount, 2);

`ifdef KEYPAD_REPEAT_EN
    // 6. auto-repeat: accept at tick 60, repeats at 110, 130, 150, 170
    restart();
    go_to(10);  pressed[10] = 1'b1;
    go_to(60);  chk("rpt_accept", {3'b0, kp.key_valid}, 4'd1);
    go_to(110); chk("rpt_first",  {3'b0, kp.key_valid}, 4'd1);
    go_to(120); chk("rpt_gap",    {3'b0, kp.key_valid}, 4'd0);
    go_to(130); chk("rpt_second", {3'b0, kp.key_valid}, 4'd1);
                chk("rpt_code",   kp.key_code, 4'd10);
    go_to(150); chk("rpt_third",  {3'b0, kp.key_valid}, 4'd1);
    go_to(170); chk("rpt_fourth", {3'b0, kp.key_valid}, 4'd1);
    go_to(175); pressed = '0;
    go_to(180);
    chk_n("rpt_total_valid", vcount, 7);
`endif

    chk_n("valid_never_2clk", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
